// File: rtl/fei4_cmd_pkg.sv
// fei4_cmd_pkg: FE-I4 command codes and frame constants shared by encoder and decoder.
package fei4_cmd_pkg;
  typedef enum logic [3:0] {
    CMD_TRIG, CMD_BCR, CMD_ECR, CMD_CAL, CMD_RDREG, CMD_WRREG,
    CMD_WRFE, CMD_RESET, CMD_PULSE, CMD_RUNSET, CMD_RUNCLR
  } cmd_type_t;
  localparam logic [4:0] TRIG_H      = 5'b11101;
  localparam logic [4:0] FAST_H      = 5'b10110;
  localparam logic [3:0] SLOW_H      = 4'b1000;
  localparam logic [3:0] FAST_BCR    = 4'b0001;
  localparam logic [3:0] FAST_ECR    = 4'b0010;
  localparam logic [3:0] FAST_CAL    = 4'b0100;
  localparam logic [3:0] SLOW_RDREG  = 4'b0001;
  localparam logic [3:0] SLOW_WRREG  = 4'b0010;
  localparam logic [3:0] SLOW_WRFE   = 4'b0100;
  localparam logic [3:0] SLOW_RESET  = 4'b1000;
  localparam logic [3:0] SLOW_PULSE  = 4'b1001;
  localparam logic [3:0] SLOW_RUN    = 4'b1010;
  localparam logic [5:0] RUNSET_F    = 6'b111000;
  localparam logic [5:0] RUNCLR_F    = 6'b000111;
  localparam int         FRAME_W     = 39;
  function automatic logic [16:0] slow_hdr(input logic [3:0] code, input logic bcast, input logic [2:0] chip);
    return {FAST_H, SLOW_H, code, bcast, chip};
  endfunction
endpackage

// File: rtl/fei4_frame_build.sv
// fei4_frame_build: maps a command request to a left-aligned frame, its bit length and trailing idle gap.
module fei4_frame_build
  import fei4_cmd_pkg::*;
#(
  parameter int ECR_GAP   = 16,
  parameter int RDREG_GAP = 16
) (
  input  logic [3:0]         cmd_type,
  input  logic [2:0]         chip,
  input  logic               bcast,
  input  logic [5:0]         addr,
  input  logic [15:0]        data,
  output logic [FRAME_W-1:0] frame,
  output logic [5:0]         len,
  output logic [6:0]         gap,
  output logic               err,
  output logic               fe
);
  always_comb begin
    frame = '0;
    len   = '0;
    gap   = '0;
    err   = 1'b0;
    fe    = 1'b0;
    case (cmd_type)
      CMD_TRIG:   begin frame = {TRIG_H, 34'd0}; len = 6'd5; end
      CMD_BCR:    begin frame = {FAST_H, FAST_BCR, 30'd0}; len = 6'd9; end
      CMD_ECR:    begin frame = {FAST_H, FAST_ECR, 30'd0}; len = 6'd9; gap = 7'(ECR_GAP); end
      CMD_CAL:    begin frame = {FAST_H, FAST_CAL, 30'd0}; len = 6'd9; end
      CMD_RDREG:  begin frame = {slow_hdr(SLOW_RDREG, bcast, chip), addr, 16'd0}; len = 6'd23; gap = 7'(RDREG_GAP); end
      CMD_WRREG:  begin frame = {slow_hdr(SLOW_WRREG, bcast, chip), addr, data}; len = 6'd39; end
      CMD_WRFE:   begin frame = {slow_hdr(SLOW_WRFE, bcast, chip), addr, 16'd0}; len = 6'd23; fe = 1'b1; end
      CMD_RESET:  begin frame = {slow_hdr(SLOW_RESET, bcast, chip), 22'd0}; len = 6'd17; end
      CMD_PULSE:  begin frame = {slow_hdr(SLOW_PULSE, bcast, chip), addr, 16'd0}; len = 6'd23; gap = {1'b0, addr} + 7'd1; end
      CMD_RUNSET: begin frame = {slow_hdr(SLOW_RUN, bcast, chip), RUNSET_F, 16'd0}; len = 6'd23; end
      CMD_RUNCLR: begin frame = {slow_hdr(SLOW_RUN, bcast, chip), RUNCLR_F, 16'd0}; len = 6'd23; end
      default:    err = 1'b1;
    endcase
  end
endmodule

// File: rtl/fei4_cmd_encoder.sv
// fei4_cmd_encoder: serializes FE-I4 trigger/fast/slow commands onto the CMD line, MSB first, with mandatory idle gaps.
module fei4_cmd_encoder
  import fei4_cmd_pkg::*;
#(
  parameter int ECR_GAP   = 16,
  parameter int RDREG_GAP = 16,
  parameter int FE_BITS   = 672
) (
  input  logic        CK,
  input  logic        RstB,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [3:0]  CmdType,
  input  logic [2:0]  CmdChipId,
  input  logic        CmdBroadcast,
  input  logic [5:0]  CmdAddr,
  input  logic [15:0] CmdData,
  output logic        FeBitRd,
  input  logic        FeBit,
  output logic        CmdOut,
  output logic        Busy,
  output logic        CmdErr
);
  typedef enum logic [1:0] {IDLE, SHIFT, FESTREAM, GAP} state_t;
  state_t state, nxt;
  logic [FRAME_W-1:0] f_frame, sr;
  logic [5:0] f_len, len_cnt;
  logic [6:0] f_gap, gap_q, gap_cnt;
  logic [9:0] fe_cnt;
  logic f_err, f_fe, fe_q, take;
  fei4_frame_build #(.ECR_GAP(ECR_GAP), .RDREG_GAP(RDREG_GAP)) u_build (
    .cmd_type(CmdType), .chip(CmdChipId), .bcast(CmdBroadcast), .addr(CmdAddr), .data(CmdData),
    .frame(f_frame), .len(f_len), .gap(f_gap), .err(f_err), .fe(f_fe)
  );
  assign take    = CmdValid & CmdReady;
  assign Busy    = state != IDLE;
  assign FeBitRd = state == FESTREAM;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = (take && !f_err) ? SHIFT : IDLE;
      SHIFT:    nxt = (len_cnt != 6'd0) ? SHIFT : fe_q ? FESTREAM : (gap_q != 7'd0) ? GAP : IDLE;
      FESTREAM: nxt = (fe_cnt == 10'd0) ? GAP : FESTREAM;
      GAP:      nxt = (gap_cnt == 7'd1) ? IDLE : GAP;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge CK or negedge RstB) begin
    if (!RstB) state <= IDLE;
    else state <= nxt;
  end
  // The last streamed WrFE bit appears one cycle after its pop, so a one-cycle GAP tail keeps it off IDLE.
  always_ff @(posedge CK or negedge RstB) begin
    if (!RstB) begin
      CmdOut   <= 1'b0;
      CmdErr   <= 1'b0;
      CmdReady <= 1'b0;
      sr       <= '0;
      len_cnt  <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      fe_cnt   <= '0;
      fe_q     <= 1'b0;
    end else begin
      CmdOut   <= 1'b0;
      CmdErr   <= 1'b0;
      CmdReady <= nxt == IDLE;
      case (state)
        IDLE: begin
          CmdErr <= take & f_err;
          if (take && !f_err) begin
            CmdOut  <= f_frame[FRAME_W-1];
            sr      <= {f_frame[FRAME_W-2:0], 1'b0};
            len_cnt <= f_len - 6'd1;
            gap_q   <= f_gap;
            gap_cnt <= f_gap;
            fe_q    <= f_fe;
          end
        end
        SHIFT: begin
          fe_cnt <= 10'(FE_BITS - 1);
          if (len_cnt != 6'd0) begin
            CmdOut  <= sr[FRAME_W-1];
            sr      <= {sr[FRAME_W-2:0], 1'b0};
            len_cnt <= len_cnt - 6'd1;
          end
        end
        FESTREAM: begin
          CmdOut  <= FeBit;
          fe_cnt  <= fe_cnt - 10'd1;
          gap_cnt <= 7'd1;
        end
        GAP: gap_cnt <= gap_cnt - 7'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fei4_cmd_encoder.sv
// tb_fei4_cmd_encoder: table-driven frame/gap checks plus WrFE streaming, mid-frame reset and unknown-command sequences.
module tb_fei4_cmd_encoder;
  logic CK = 1'b0, RstB = 1'b1, CmdValid = 1'b0, CmdBroadcast = 1'b0, fe_tog = 1'b0;
  logic [3:0] CmdType = '0;
  logic [2:0] CmdChipId = '0;
  logic [5:0] CmdAddr = '0;
  logic [15:0] CmdData = '0;
  logic CmdReady, FeBitRd, FeBit, CmdOut, Busy, CmdErr;
  int checks = 0, failures = 0;
  typedef struct {
    logic [3:0]  typ;
    logic [2:0]  chip;
    logic        b;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [38:0] frame;
    int          len;
    int          gap;
    string       name;
  } vec_t;
  vec_t tbl[11];
  always #5 CK = ~CK;
  assign FeBit = fe_tog;
  always @(posedge CK) if (FeBitRd) fe_tog <= ~fe_tog;
  fei4_cmd_encoder dut (
    .CK(CK), .RstB(RstB), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdType(CmdType),
    .CmdChipId(CmdChipId), .CmdBroadcast(CmdBroadcast), .CmdAddr(CmdAddr), .CmdData(CmdData),
    .FeBitRd(FeBitRd), .FeBit(FeBit), .CmdOut(CmdOut), .Busy(Busy), .CmdErr(CmdErr)
  );
  task automatic tick;
    @(posedge CK);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] t, input logic [2:0] c, input logic b, input logic [5:0] a, input logic [15:0] d);
    int n = 0;
    while (!CmdReady && n < 200) begin
      tick;
      n++;
    end
    check("ready_wait", CmdReady, 1);
    CmdType = t; CmdChipId = c; CmdBroadcast = b; CmdAddr = a; CmdData = d;
    CmdValid = 1'b1;
    tick;
    CmdValid = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    logic [38:0] got = '0;
    int bad = 0;
    issue(v.typ, v.chip, v.b, v.addr, v.data);
    check({v.name, "_no_err"}, CmdErr, 0);
    for (int k = 0; k < v.len; k++) begin
      got[38-k] = CmdOut;
      tick;
    end
    check({v.name, "_frame"}, got, v.frame);
    for (int g = 0; g < v.gap; g++) begin
      if (CmdOut !== 1'b0 || CmdReady !== 1'b0 || Busy !== 1'b1) bad++;
      tick;
    end
    check({v.name, "_gap_bad_cycles"}, bad, 0);
    check({v.name, "_ready_after"}, CmdReady, 1);
    check({v.name, "_idle_out"}, CmdOut, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [38:0] got;
    int bad, pulses;
    logic prv_rd, prv_bit;
    tbl[0]  = '{4'd0,  3'd0, 1'b0, 6'd0,  16'h0,    {5'b11101, 34'd0}, 5, 0, "trig"};
    tbl[1]  = '{4'd2,  3'd0, 1'b0, 6'd0,  16'h0,    {9'b101100010, 30'd0}, 9, 16, "ecr"};
    tbl[2]  = '{4'd1,  3'd0, 1'b0, 6'd0,  16'h0,    {9'b101100001, 30'd0}, 9, 0, "bcr"};
    tbl[3]  = '{4'd3,  3'd0, 1'b0, 6'd0,  16'h0,    {9'b101100100, 30'd0}, 9, 0, "cal"};
    tbl[4]  = '{4'd5,  3'd3, 1'b0, 6'h05, 16'hA5C3, {5'b10110, 4'b1000, 4'b0010, 4'b0011, 6'b000101, 16'hA5C3}, 39, 0, "wrreg"};
    tbl[5]  = '{4'd4,  3'd2, 1'b1, 6'h2A, 16'hFFFF, {5'b10110, 4'b1000, 4'b0001, 4'b1010, 6'b101010, 16'h0}, 23, 16, "rdreg"};
    tbl[6]  = '{4'd7,  3'd7, 1'b0, 6'h3F, 16'hFFFF, {5'b10110, 4'b1000, 4'b1000, 4'b0111, 22'd0}, 17, 0, "reset"};
    tbl[7]  = '{4'd8,  3'd1, 1'b0, 6'd10, 16'h0,    {5'b10110, 4'b1000, 4'b1001, 4'b0001, 6'b001010, 16'h0}, 23, 11, "pulse10"};
    tbl[8]  = '{4'd9,  3'd7, 1'b1, 6'd0,  16'h0,    {5'b10110, 4'b1000, 4'b1010, 4'b1111, 6'b111000, 16'h0}, 23, 0, "runset"};
    tbl[9]  = '{4'd10, 3'd0, 1'b0, 6'd0,  16'h0,    {5'b10110, 4'b1000, 4'b1010, 4'b0000, 6'b000111, 16'h0}, 23, 0, "runclr"};
    tbl[10] = '{4'd8,  3'd5, 1'b1, 6'd0,  16'h0,    {5'b10110, 4'b1000, 4'b1001, 4'b1101, 6'b000000, 16'h0}, 23, 1, "pulse0"};
    #3 RstB = 1'b0;
    #1;
    check("rst_cmdout", CmdOut, 0);
    check("rst_ready", CmdReady, 0);
    check("rst_busy", Busy, 0);
    check("rst_febitrd", FeBitRd, 0);
    check("rst_err", CmdErr, 0);
    tick;
    tick;
    RstB = 1'b1;
    tick;
    check("ready_after_release", CmdReady, 1);
    foreach (tbl[i]) run_vec(tbl[i]);
    issue(4'd6, 3'd0, 1'b0, 6'd3, 16'h0);
    got = '0;
    bad = 0;
    for (int k = 0; k < 23; k++) begin
      got[38-k] = CmdOut;
      if (FeBitRd !== 1'b0) bad++;
      tick;
    end
    check("wrfe_header", got, {5'b10110, 4'b1000, 4'b0100, 4'b0000, 6'b000011, 16'h0});
    check("wrfe_no_early_rd", bad, 0);
    check("wrfe_rd_start", FeBitRd, 1);
    bad = 0;
    pulses = 0;
    prv_rd = 1'b0;
    prv_bit = 1'b0;
    for (int n = 0; n < 700; n++) begin
      if (prv_rd && CmdOut !== prv_bit) bad++;
      if (!prv_rd && pulses > 0 && CmdOut !== 1'b0) bad++;
      if (FeBitRd) pulses++;
      prv_rd = FeBitRd;
      prv_bit = FeBit;
      tick;
    end
    check("wrfe_pulses", pulses, 672);
    check("wrfe_mirror_bad", bad, 0);
    check("wrfe_done_busy", Busy, 0);
    check("wrfe_done_ready", CmdReady, 1);
    issue(4'd5, 3'd3, 1'b0, 6'h05, 16'hA5C3);
    for (int k = 0; k < 20; k++) tick;
    check("midrst_bit20", CmdOut, 1);
    RstB = 1'b0;
    #1;
    check("midrst_cmdout", CmdOut, 0);
    check("midrst_busy", Busy, 0);
    tick;
    tick;
    RstB = 1'b1;
    check("midrst_ready_low", CmdReady, 0);
    tick;
    check("midrst_ready", CmdReady, 1);
    bad = 0;
    for (int k = 0; k < 45; k++) begin
      if (CmdOut !== 1'b0 || Busy !== 1'b0) bad++;
      tick;
    end
    check("midrst_no_resume", bad, 0);
    issue(4'd15, 3'd0, 1'b0, 6'd0, 16'h0);
    check("unk_err_pulse", CmdErr, 1);
    check("unk_busy", Busy, 0);
    check("unk_ready", CmdReady, 1);
    bad = 0;
    tick;
    check("unk_err_single", CmdErr, 0);
    for (int k = 0; k < 10; k++) begin
      if (CmdOut !== 1'b0 || CmdErr !== 1'b0) bad++;
      tick;
    end
    check("unk_silent", bad, 0);
    issue(4'd11, 3'd0, 1'b0, 6'd0, 16'h0);
    check("unk11_err", CmdErr, 1);
    check("unk11_cmdout", CmdOut, 0);
    run_vec(tbl[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
